key_cmd_queue: RTL

KEY_CMD_QUEUE -- requirements
Module: key_cmd_queue

---
 rtl/key_cmd_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/key_cmd_queue.sv
// Keyboard/gravity command FIFO feeding the game logic with a ready/valid head.
// Optional gravity timer enabled by defining DROP_TIMER_EN.
module key_cmd_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DROP_PERIOD = 25000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     left,
  input  logic                     right,
  input  logic                     up,
  input  logic                     down,
  input  logic                     pause,
  input  logic                     cmd_ready,
  output logic                     cmd_valid,
  output logic [1:0]               cmd_code,
  output logic                     cmd_auto,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    key_cnt;
  logic          key_any;
  logic          multi_key;
  logic          tick_push;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;
  logic [2:0]    push_data;
  logic [2:0]    head_nxt;
  logic [LW-1:0] level_nxt;

  // Push arbitration, handshake and next head of queue
  always_comb begin
    key_cnt   = 3'(down) + 3'(left) + 3'(right) + 3'(up);
    key_any   = (key_cnt != 3'd0);
    multi_key = (key_cnt > 3'd1);
    push_req  = key_any | tick_push;
    push_data = 3'b000;
    if (down)           push_data = 3'b011;
    else if (left)      push_data = 3'b000;
    else if (right)     push_data = 3'b001;
    else if (up)        push_data = 3'b010;
    else if (tick_push) push_data = 3'b111;
    pop       = cmd_valid & cmd_ready;
    full      = (level == LW'(DEPTH));
    push_ok   = push_req & (~full | pop);
    drop      = push_req & full & ~pop;
    level_nxt = LW'(level + LW'(push_ok) - LW'(pop));
    head_nxt  = {cmd_auto, cmd_code};
    if (level_nxt == '0)
      head_nxt = 3'b000;
    else if (pop)
      head_nxt = (level == LW'(1)) ? push_data : mem[PW'(rd_ptr + 1'b1)];
    else if (level == '0)
      head_nxt = push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= 2'b00;
      cmd_auto  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= PW'(wr_ptr + 1'b1);
      if (pop)     rd_ptr <= PW'(rd_ptr + 1'b1);
      level                <= level_nxt;
      cmd_valid            <= (level_nxt != '0);
      {cmd_auto, cmd_code} <= head_nxt;
      overflow             <= overflow | multi_key | drop;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= push_data;
  end

`ifdef DROP_TIMER_EN
  localparam int unsigned CW = $clog2(DROP_PERIOD);

  logic [CW-1:0] drop_cnt;
  logic          tick_pend;
  logic          wrap;

  assign wrap      = ~pause & (drop_cnt == CW'(DROP_PERIOD - 1));
  assign tick_push = tick_pend & ~key_any;

  // A key DOWN that lands in the queue restarts gravity; a new wrap beats a consumed tick
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt  <= '0;
      tick_pend <= 1'b0;
    end else if (down && push_ok) begin
      drop_cnt  <= '0;
      tick_pend <= 1'b0;
    end else begin
      if (!pause) drop_cnt <= wrap ? '0 : CW'(drop_cnt + 1'b1);
      if (wrap)           tick_pend <= 1'b1;
      else if (tick_push) tick_pend <= 1'b0;
    end
  end
`else
  logic        pause_unused;
  logic [31:0] period_unused;

  assign pause_unused  = pause;
  assign period_unused = 32'(DROP_PERIOD);
  assign tick_push     = 1'b0;
`endif

endmodule
